// File: rtl/rtu_port_req_arbiter_pkg.sv
// Shared types and helper functions for the RTU port request arbiter.
package rtu_arb_pkg;

  localparam int unsigned TAG_W = 5;

  // Port index carried through the in-order tag FIFO (covers up to 32 ports).
  typedef logic [TAG_W-1:0] t_rtu_arb_tag;

  // Number of address bits needed to index n entries.
  function automatic int unsigned f_log2_size(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // One-hot grant of the first set request strictly after ptr, wrapping at n.
  function automatic logic [31:0] f_rr_select(input logic [31:0] req,
                                              input t_rtu_arb_tag ptr,
                                              input int unsigned n);
    logic [31:0] grant;
    logic [TAG_W-1:0] idx;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 32; i++) begin
      idx = TAG_W'((32'(ptr) + i) % n);
      if (i <= n && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rtu_port_req_arbiter_tag_fifo.sv
// In-order FIFO of granted port indices; entries are only reset via the pointers.
module rtu_arb_tag_fifo
  import rtu_arb_pkg::*;
#(
  parameter int unsigned g_depth = 4,
  localparam int unsigned AW = f_log2_size(g_depth)
) (
  input  logic         clk_sys_i,
  input  logic         rst_n_i,
  input  logic         push,
  input  t_rtu_arb_tag push_tag,
  input  logic         pop,
  output t_rtu_arb_tag head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  t_rtu_arb_tag  mem [g_depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(g_depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/rtu_port_req_arbiter.sv
// Round-robin arbiter sharing one RTU engine between endpoint request channels,
// routing in-order engine responses back to per-port response slots.
module rtu_port_req_arbiter
  import rtu_arb_pkg::*;
#(
  parameter int unsigned g_num_ports    = 6,
  parameter int unsigned g_req_width    = 100,
  parameter int unsigned g_rsp_width    = 32,
  parameter int unsigned g_max_inflight = 4
) (
  input  logic                               clk_sys_i,
  input  logic                               rst_n_i,
  input  logic [g_num_ports-1:0]             rq_valid_i,
  input  logic [g_num_ports*g_req_width-1:0] rq_data_i,
  output logic [g_num_ports-1:0]             rq_ready_o,
  output logic                               eng_rq_valid_o,
  output logic [g_req_width-1:0]             eng_rq_data_o,
  input  logic                               eng_rq_ready_i,
  input  logic                               eng_rsp_valid_i,
  input  logic [g_rsp_width-1:0]             eng_rsp_data_i,
  output logic                               eng_rsp_ready_o,
  output logic [g_num_ports-1:0]             rsp_valid_o,
  output logic [g_num_ports*g_rsp_width-1:0] rsp_data_o,
  input  logic [g_num_ports-1:0]             rsp_ack_i,
  output logic [f_log2_size(g_max_inflight):0] inflight_o,
  output logic                               err_unexp_rsp_o
);

  logic [31:0]                        rr_sel;
  logic                               unused_rr_sel;
  t_rtu_arb_tag                       rr_ptr;
  t_rtu_arb_tag                       grant_tag;
  t_rtu_arb_tag                       head;
  logic [g_num_ports-1:0]             grant_oh;
  logic [g_num_ports-1:0]             head_oh;
  logic [g_req_width-1:0]             grant_data;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               can_accept;
  logic                               grant_en;
  logic                               rsp_fire;
  logic                               rsp_pop;
  logic                               eng_rq_vld_p1;
  logic [g_req_width-1:0]             eng_rq_data_p1;
  logic [g_num_ports-1:0]             rsp_vld_p1;
  logic [g_num_ports*g_rsp_width-1:0] rsp_data_p1;
  logic                               err_p1;

  // A full tag FIFO blocks grants even when a pop happens in the same cycle.
  assign can_accept    = (~eng_rq_vld_p1 | eng_rq_ready_i) & ~fifo_full;
  assign grant_en      = can_accept & (|rq_valid_i);
  assign rr_sel        = f_rr_select(32'(rq_valid_i), rr_ptr, g_num_ports);
  assign unused_rr_sel = ^rr_sel;

  always_comb begin
    grant_oh   = '0;
    grant_tag  = '0;
    grant_data = '0;
    for (int k = 0; k < int'(g_num_ports); k++) begin
      if (rr_sel[k]) begin
        grant_oh[k] = grant_en;
        grant_tag   = t_rtu_arb_tag'(k);
        grant_data  = rq_data_i[k*g_req_width +: g_req_width];
      end
    end
  end

  always_comb begin
    head_oh = '0;
    for (int k = 0; k < int'(g_num_ports); k++) begin
      head_oh[k] = ~fifo_empty & (head == t_rtu_arb_tag'(k));
    end
  end

  // With no tag outstanding the response is swallowed and flagged.
  assign eng_rsp_ready_o = fifo_empty | (|(head_oh & (~rsp_vld_p1 | rsp_ack_i)));
  assign rsp_fire        = eng_rsp_valid_i & eng_rsp_ready_o;
  assign rsp_pop         = rsp_fire & ~fifo_empty;

  rtu_arb_tag_fifo #(
    .g_depth (g_max_inflight)
  ) u_tag_fifo (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .push      (grant_en),
    .push_tag  (grant_tag),
    .pop       (rsp_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight_o)
  );

  // Stage p1: registered request towards the engine
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      eng_rq_vld_p1  <= 1'b0;
      eng_rq_data_p1 <= '0;
      rr_ptr         <= t_rtu_arb_tag'(g_num_ports - 1);
    end else if (grant_en) begin
      eng_rq_vld_p1  <= 1'b1;
      eng_rq_data_p1 <= grant_data;
      rr_ptr         <= grant_tag;
    end else if (eng_rq_ready_i) begin
      eng_rq_vld_p1  <= 1'b0;
    end
  end

  // Stage p1: per-port response slots; a reload wins over a same-cycle ack
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      rsp_vld_p1  <= '0;
      rsp_data_p1 <= '0;
      err_p1      <= 1'b0;
    end else begin
      if (eng_rsp_valid_i & fifo_empty) err_p1 <= 1'b1;
      for (int k = 0; k < int'(g_num_ports); k++) begin
        if (rsp_pop & head_oh[k]) begin
          rsp_vld_p1[k]                               <= 1'b1;
          rsp_data_p1[k*g_rsp_width +: g_rsp_width] <= eng_rsp_data_i;
        end else if (rsp_ack_i[k]) begin
          rsp_vld_p1[k] <= 1'b0;
        end
      end
    end
  end

  assign rq_ready_o      = grant_oh;
  assign eng_rq_valid_o  = eng_rq_vld_p1;
  assign eng_rq_data_o   = eng_rq_data_p1;
  assign rsp_valid_o     = rsp_vld_p1;
  assign rsp_data_o      = rsp_data_p1;
  assign err_unexp_rsp_o = err_p1;

endmodule
